// File: rtl/clk_step_ctrl.sv
// CPU clock-enable generator: run mode follows a clkdiv tap, step mode follows a debounced button.
// Optional macro STEP_CNT_EN adds the 32-bit cpu_en pulse counter on step_cnt.
module clk_step_ctrl #(
  parameter int unsigned     DB_W      = 20,
  parameter logic [DB_W-1:0] DB_CYCLES = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clkdiv,
  input  logic [4:0]  sel,
  input  logic        mode,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic        btn_db,
  output logic [31:0] step_cnt
);

  localparam logic [DB_W-1:0] DbOne  = {{(DB_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0] DbLast = DB_CYCLES - DbOne;

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StRelWait} db_state_e;

  db_state_e       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            sync1_q, btn_s;
  logic            tap_q;
  logic [4:0]      sel_q;
  logic            tap_cur, tap_rise, step_req, en_d;

  assign tap_cur = clkdiv[sel];
  // A freshly changed select compares against a stale tap_q, so its edge is ignored.
  assign tap_rise = tap_cur & ~tap_q & (sel == sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q   <= 1'b0;
      sel_q   <= 5'd0;
      sync1_q <= 1'b0;
      btn_s   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      cpu_en  <= 1'b0;
    end else begin
      tap_q   <= tap_cur;
      sel_q   <= sel;
      sync1_q <= step_btn;
      btn_s   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpu_en  <= en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          state_d  = StPressed;
          step_req = 1'b1;
        end else begin
          cnt_d = cnt_q + DbOne;
        end
      end
      StPressed: begin
        if (!btn_s) begin
          state_d = StRelWait;
          cnt_d   = '0;
        end
      end
      StRelWait: begin
        if (btn_s) begin
          state_d = StPressed;
        end else if (cnt_q == DbLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + DbOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign btn_db = (state_q == StPressed) || (state_q == StRelWait);

  // Events from the inactive source are dropped, never queued.
  assign en_d = ~halt & (mode ? step_req : tap_rise);

`ifdef STEP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 32'd0;
    end else if (cpu_en) begin
      step_cnt <= step_cnt + 32'd1;
    end
  end
`else
  assign step_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Randomized bench for clk_step_ctrl against a cycle-level behavioural model.
module tb_clk_step_ctrl;
  localparam int unsigned DbW  = 8;
  localparam int unsigned DbCy = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] clkdiv = 32'd0;
  logic [4:0]  sel = 5'd0;
  logic        mode = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_en, btn_db;
  logic [31:0] step_cnt;

  clk_step_ctrl #(
    .DB_W     (DbW),
    .DB_CYCLES(8'(DbCy))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clkdiv  (clkdiv),
    .sel     (sel),
    .mode    (mode),
    .step_btn(step_btn),
    .halt    (halt),
    .cpu_en  (cpu_en),
    .btn_db  (btn_db),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the button level flips after DbCy+1 consecutive synchronized samples disagreeing.
  bit          m_tap;
  logic [4:0]  m_sel;
  bit   [1:0]  m_sync;
  bit          m_level;
  int          m_run;
  bit          m_en;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_tap = 0; m_sel = 5'd0; m_sync = 2'b00; m_level = 0; m_run = 0; m_en = 0; m_cnt = 32'd0;
  endtask

  task automatic compare_all();
    check("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
    check("btn_db", {31'd0, btn_db}, {31'd0, m_level});
    check("step_cnt", step_cnt, m_cnt);
  endtask

  // One clock edge; inputs are stable from before the edge until this returns.
  task automatic tick();
    bit tap, rise, req, btn_s;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      tap   = clkdiv[sel];
      rise  = tap && !m_tap && (sel == m_sel);
      btn_s = m_sync[1];
      req   = 0;
      if (btn_s != m_level) begin
        m_run++;
        if (m_run == DbCy + 1) begin
          req     = !m_level;
          m_level = !m_level;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
`ifdef STEP_CNT_EN
      if (m_en) m_cnt = m_cnt + 32'd1;
`endif
      m_en   = !halt && (mode ? req : rise);
      m_tap  = tap;
      m_sel  = sel;
      m_sync = {m_sync[0], step_btn};
    end
    compare_all();
    clkdiv = clkdiv + 32'd1;
  endtask

  int pulses;
  int first_en;
  int btn_left;

  initial begin
    model_reset();
    #2;
    compare_all();
    // Run mode, tap 2: one pulse per 8 cycles.
    sel = 5'd2;
    #10 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_en) pulses++;
    end
    check("run_pulses", pulses, 5);

    // Async reset while in press qualification, button held.
    mode = 1'b1;
    step_btn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    first_en = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cpu_en && first_en < 0) first_en = k;
    end
    check("req036_latency", first_en, DbCy + 3);

    // Randomized mix of mode, halt, tap select, bouncing button and rare resets.
    btn_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (btn_left == 0) begin
        step_btn = ~step_btn;
        btn_left = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 16) : $urandom_range(1, 3);
      end
      btn_left--;
      if ($urandom_range(0, 99) == 0) halt = ~halt;
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0) sel = 5'($urandom_range(0, 6));
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
